// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// FSM state encoding, PC width and instruction size.
package fetch_pkg;

  localparam int unsigned          PC_W             = 32;
  localparam int unsigned          INSTR_BYTES      = 4;
  localparam logic [PC_W-1:0]      RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: redirect/stall inputs, instruction-memory port and decode bundle.
// master = fetch unit, slave = surrounding pipeline and memory.
interface pc_fetch_unit_if;
  import fetch_pkg::*;

  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            jump;
  logic [PC_W-1:0] jump_target;
  logic [PC_W-1:0] read_address;
  logic [31:0]     instruction;
  logic [31:0]     if_instr;
  logic [PC_W-1:0] if_pc;
  logic [PC_W-1:0] if_pc_plus4;
  logic            if_valid;
  logic            fault;
  logic [31:0]     fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target, instruction,
    output read_address, if_instr, if_pc, if_pc_plus4, if_valid, fault, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, instruction,
    input  read_address, if_instr, if_pc, if_pc_plus4, if_valid, fault, fetch_count
  );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (jump > branch > stall > sequential) plus alignment/range check.
// Purely combinational; stall selects the current PC.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 256
) (
  input  logic [PC_W-1:0] pc,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            stall,
  output logic [PC_W-1:0] next_pc,
  output logic            fault_detect
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(IMEM_BYTES - INSTR_BYTES);

  logic [PC_W:0] seq_pc;
  logic          seq_wrap;

  always_comb begin
    seq_pc   = {1'b0, pc} + (PC_W+1)'(INSTR_BYTES);
    seq_wrap = 1'b0;
    next_pc  = seq_pc[PC_W-1:0];
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else if (stall) begin
      next_pc = pc;
    end else begin
      // Carry out of pc+4 is an out-of-range target even though the low bits look legal.
      seq_wrap = seq_pc[PC_W];
    end
    fault_detect = (next_pc[1:0] != 2'b00) || (next_pc > LAST_PC) || seq_wrap;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns PC, addresses memory with next PC, emits {instr, pc} bundle.
// Zero added latency over the memory's one-cycle read; stall holds PC and re-reads the same word.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     IMEM_BYTES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_fetch_unit_if.master   fif
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     fetch_count_q, fetch_count_d;
  logic [PC_W-1:0] next_pc;
  logic            fault_detect;
  logic [PC_W-1:0] read_address;

  pc_next_sel #(
    .IMEM_BYTES (IMEM_BYTES)
  ) u_pc_next_sel (
    .pc            (pc_q),
    .jump          (fif.jump),
    .jump_target   (fif.jump_target),
    .branch_taken  (fif.branch_taken),
    .branch_target (fif.branch_target),
    .stall         (fif.stall),
    .next_pc       (next_pc),
    .fault_detect  (fault_detect)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    read_address  = pc_q;
    case (state_q)
      BOOT: begin
        read_address = RESET_PC;
        pc_d         = RESET_PC;
        state_d      = RUN;
      end
      RUN: begin
        // An illegal target never reaches memory: keep re-reading the current word.
        if (fault_detect) begin
          state_d = FAULT;
        end else begin
          read_address = next_pc;
          pc_d         = next_pc;
          if (!fif.stall) begin
            fetch_count_d = fetch_count_q + 32'd1;
          end
        end
      end
      FAULT: begin
        read_address = pc_q;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign fif.read_address = read_address;
  assign fif.if_instr     = fif.instruction;
  assign fif.if_pc        = pc_q;
  assign fif.if_pc_plus4  = pc_q + PC_W'(INSTR_BYTES);
  assign fif.if_valid     = (state_q == RUN);
  assign fif.fault        = (state_q == FAULT);
  assign fif.fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a 256-byte big-endian instruction memory model.
module tb_pc_fetch_unit;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [7:0] mem [256];

  pc_fetch_unit_if fif ();

  pc_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (256)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (a == 32'h0) return 32'h014B_4820;
    return {16'hC0DE, a[15:0]};
  endfunction

  // Synchronous memory: word at read_address appears the cycle after.
  always @(posedge clk) begin
    fif.instruction <= {mem[int'(fif.read_address[7:0])],
                        mem[int'(fif.read_address[7:0]) + 1],
                        mem[int'(fif.read_address[7:0]) + 2],
                        mem[int'(fif.read_address[7:0]) + 3]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    fif.stall         = 1'b0;
    fif.branch_taken  = 1'b0;
    fif.branch_target = 32'h0;
    fif.jump          = 1'b0;
    fif.jump_target   = 32'h0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'd0, fif.if_valid}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fif.fault}, 32'd0);
    chk({tag, "_cnt"}, fif.fetch_count, 32'd0);
    chk({tag, "_ra"}, fif.read_address, 32'h0);
    chk({tag, "_pc"}, fif.if_pc, 32'h0);
    chk({tag, "_pc4"}, fif.if_pc_plus4, 32'h4);
  endtask

  // Assert reset between edges, check outputs immediately, release and check BOOT.
  task automatic reset_mid(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals(tag);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk({tag, "_boot_valid"}, {31'd0, fif.if_valid}, 32'd0);
    chk({tag, "_boot_ra"}, fif.read_address, 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    n_vec = 0;
    n_err = 0;
    for (int a = 0; a < 256; a += 4) begin
      w          = instr_of(32'(a));
      mem[a]     = w[31:24];
      mem[a + 1] = w[23:16];
      mem[a + 2] = w[15:8];
      mem[a + 3] = w[7:0];
    end
    rst_n = 1'b0;
    clear_redirects();
    #2;
    chk_reset_vals("rst");

    #6;
    rst_n = 1'b1;
    #1;
    chk("boot_ra", fif.read_address, 32'h0);
    chk("boot_valid", {31'd0, fif.if_valid}, 32'd0);

    step();
    chk("run0_pc", fif.if_pc, 32'h0);
    chk("run0_instr", fif.if_instr, 32'h014B_4820);
    chk("run0_valid", {31'd0, fif.if_valid}, 32'd1);
    chk("run0_ra", fif.read_address, 32'h4);
    step();
    chk("run1_pc", fif.if_pc, 32'h4);
    chk("run1_cnt", fif.fetch_count, 32'd1);
    step();
    chk("run2_pc", fif.if_pc, 32'h8);
    chk("run2_cnt", fif.fetch_count, 32'd2);
    chk("run2_pc4", fif.if_pc_plus4, 32'hC);

    fif.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ra", fif.read_address, 32'h8);
      step();
      chk("stall_pc", fif.if_pc, 32'h8);
      chk("stall_instr", fif.if_instr, 32'hC0DE_0008);
      chk("stall_cnt", fif.fetch_count, 32'd2);
    end
    fif.stall = 1'b0;
    step();
    chk("unstall_pc", fif.if_pc, 32'hC);
    chk("unstall_cnt", fif.fetch_count, 32'd3);

    fif.stall         = 1'b1;
    fif.branch_taken  = 1'b1;
    fif.branch_target = 32'h40;
    #1;
    chk("br_ra", fif.read_address, 32'h40);
    step();
    chk("br_pc", fif.if_pc, 32'h40);
    chk("br_instr", fif.if_instr, 32'hC0DE_0040);
    chk("br_cnt", fif.fetch_count, 32'd3);

    clear_redirects();
    fif.jump          = 1'b1;
    fif.jump_target   = 32'h80;
    fif.branch_taken  = 1'b1;
    fif.branch_target = 32'h40;
    step();
    chk("jmp_pc", fif.if_pc, 32'h80);
    chk("jmp_cnt", fif.fetch_count, 32'd4);
    clear_redirects();

    for (int i = 0; i < 31; i++) step();
    chk("end_pc", fif.if_pc, 32'hFC);
    chk("end_cnt", fif.fetch_count, 32'd35);
    chk("end_ra", fif.read_address, 32'hFC);
    chk("end_valid", {31'd0, fif.if_valid}, 32'd1);
    step();
    chk("oor_fault", {31'd0, fif.fault}, 32'd1);
    chk("oor_valid", {31'd0, fif.if_valid}, 32'd0);
    chk("oor_pc", fif.if_pc, 32'hFC);
    chk("oor_cnt", fif.fetch_count, 32'd35);
    fif.jump        = 1'b1;
    fif.jump_target = 32'h10;
    step();
    chk("flt_jmp_pc", fif.if_pc, 32'hFC);
    chk("flt_jmp_ra", fif.read_address, 32'hFC);
    chk("flt_jmp_fault", {31'd0, fif.fault}, 32'd1);
    clear_redirects();

    reset_mid("rst_flt");
    step();
    step();
    chk("rerun_pc", fif.if_pc, 32'h4);
    chk("rerun_cnt", fif.fetch_count, 32'd1);
    reset_mid("rst_run");
    step();
    chk("boot2_pc", fif.if_pc, 32'h0);
    chk("boot2_valid", {31'd0, fif.if_valid}, 32'd1);
    chk("boot2_instr", fif.if_instr, 32'h014B_4820);

    fif.branch_taken  = 1'b1;
    fif.branch_target = 32'h42;
    #1;
    chk("mis_ra", fif.read_address, 32'h0);
    step();
    chk("mis_fault", {31'd0, fif.fault}, 32'd1);
    chk("mis_pc", fif.if_pc, 32'h0);
    chk("mis_cnt", fif.fetch_count, 32'd0);
    clear_redirects();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
